multi_cycle_control_fsm: RTL

Main control state machine of the multi-cycle RV32I core: sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It produces the `alu_op` code consumed by the ALU control decoder and consumes the ALU's `alu_bcond` flags to resolve branches. It sits between the instruction register and the datapath.

---
 rtl/multi_cycle_control_fsm_pkg.sv | 36 +++
 rtl/multi_cycle_control_fsm_branch_condition.sv | 25 ++
 rtl/multi_cycle_control_fsm.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state encoding,
// datapath select encodings and the opcode/funct3 constants.
package multi_cycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB_ALU, S_WB_MEM, S_PC4, S_BR, S_JAL, S_JALR, S_ECALL
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_ALU    = 2'b10;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/multi_cycle_control_fsm_branch_condition.sv
// Resolves branch direction from funct3 and the ALU compare flags of rs1-rs2.
module branch_condition
  import multi_cycle_control_fsm_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [2:0] i_alu_bcond,
  output logic       o_taken
);

  // The greater-than flag has no consumer among the supported branches.
  logic w_unused_gt;
  assign w_unused_gt = i_alu_bcond[2];

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = i_alu_bcond[0];
      F3_BNE:  o_taken = ~i_alu_bcond[0];
      F3_BLT:  o_taken = i_alu_bcond[1];
      F3_BGE:  o_taken = ~i_alu_bcond[1];
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB and
// drives every datapath enable and mux select.
module multi_cycle_control_fsm
  import multi_cycle_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] part_of_inst,
  input  logic [2:0]  alu_bcond,
  output logic        pc_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  mem_to_reg,
  output logic        reg_write,
  output logic        pc_source,
  output logic [1:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        is_ecall
);

  state_t     r_state;
  state_t     w_next;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_taken;
  logic       w_pc4;
  logic [21:0] w_unused_inst;

  assign w_opcode      = part_of_inst[6:0];
  assign w_funct3      = part_of_inst[14:12];
  assign w_unused_inst = {part_of_inst[31:15], part_of_inst[11:7]};

  branch_condition u_bcond (
    .i_funct3    (w_funct3),
    .i_alu_bcond (alu_bcond),
    .o_taken     (w_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = S_IF;
    w_pc4      = 1'b0;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = M2R_ALUOUT;
    reg_write  = 1'b0;
    pc_source  = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    is_ecall   = 1'b0;
    case (r_state)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        w_next   = S_ID;
      end
      S_ID: begin
        // ALUOut <= PC + imm: the branch/JAL target is ready before it is needed.
        alu_src_b = SRCB_IMM;
        case (w_opcode)
          OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_JALR: w_next = S_EX;
          OP_BRANCH: w_next = S_BR;
          OP_JAL:    w_next = S_JAL;
          OP_SYSTEM: w_next = S_ECALL;
          default:   w_next = S_PC4;
        endcase
      end
      S_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = (w_opcode == OP_RTYPE) ? SRCB_REG : SRCB_IMM;
        if (w_opcode == OP_RTYPE)      alu_op = ALUOP_RTYPE;
        else if (w_opcode == OP_ITYPE) alu_op = ALUOP_ITYPE;
        case (w_opcode)
          OP_LOAD, OP_STORE:  w_next = S_MEM;
          OP_RTYPE, OP_ITYPE: w_next = S_WB_ALU;
          OP_JALR:            w_next = S_JALR;
          default:            w_next = S_PC4;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (w_opcode == OP_LOAD);
        mem_write = (w_opcode == OP_STORE);
        w_next    = (w_opcode == OP_LOAD) ? S_WB_MEM : S_PC4;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        w_pc4     = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        w_pc4      = 1'b1;
      end
      S_PC4: w_pc4 = 1'b1;
      S_BR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_SUB;
        pc_write  = w_taken;
        pc_source = w_taken;
        w_next    = w_taken ? S_IF : S_PC4;
      end
      S_JAL, S_JALR: begin
        // ALU forms PC+4 for rd while the PC loads the target held in ALUOut.
        alu_src_b  = SRCB_FOUR;
        mem_to_reg = M2R_ALU;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_source  = 1'b1;
      end
      S_ECALL: begin
        is_ecall = 1'b1;
        w_next   = S_PC4;
      end
      default: w_next = S_IF;
    endcase
    if (w_pc4) begin
      alu_src_a = 1'b0;
      alu_src_b = SRCB_FOUR;
      alu_op    = ALUOP_ADD;
      pc_source = 1'b0;
      pc_write  = 1'b1;
    end
    if (reset) begin
      pc_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = M2R_ALUOUT;
      reg_write  = 1'b0;
      pc_source  = 1'b0;
      alu_op     = ALUOP_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      is_ecall   = 1'b0;
    end
  end

endmodule
